global_mem_ld_arbiter: RTL and testbench

- Shares one global-memory load port among N_PE per-PE load units using round-robin arbitration.
- Each PE's pe_ld_unit drives its global_mem_addr/req/gnt and global_mem_data/vld pins into this block.
- An in-order tag FIFO routes each returned data word back to the PE that issued the address.
- Sits at array level, between the PE array and the global memory load interface.

---
 rtl/global_mem_ld_arbiter.sv | 153 +++++++++++++++
 tb/tb_global_mem_ld_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_mem_ld_arbiter.sv
// Round-robin arbiter sharing one global-memory load port among N_PE load units.
// An in-order tag FIFO steers each returned word back to the PE that issued it.
module global_mem_ld_arbiter #(
    parameter int N_PE            = 8,
    parameter int ADDR_L          = 24,
    parameter int DATA_L          = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_PE*ADDR_L-1:0]             pe_addr,
    input  logic [N_PE-1:0]                    pe_addr_req,
    output logic [N_PE-1:0]                    pe_addr_gnt,
    output logic [DATA_L-1:0]                  pe_data,
    output logic [N_PE-1:0]                    pe_data_vld,
    output logic [ADDR_L-1:0]                  mem_addr,
    output logic                               mem_addr_req,
    input  logic                               mem_addr_gnt,
    input  logic [DATA_L-1:0]                  mem_data,
    input  logic                               mem_data_vld,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_cnt,
    output logic                               protocol_err
);

    localparam int IDX_W = $clog2(N_PE);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W:0]   N_PE_EXT = (IDX_W+1)'(N_PE);
    localparam logic [IDX_W-1:0] LAST_PE  = IDX_W'(N_PE - 1);

    logic [IDX_W-1:0]  r_rr_ptr;
    logic [ADDR_L-1:0] r_mem_addr;
    logic              r_mem_addr_req;
    logic [DATA_L-1:0] r_pe_data;
    logic [N_PE-1:0]   r_pe_data_vld;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [IDX_W-1:0]  r_tag [MAX_OUTSTANDING];

    logic              w_slot_free;
    logic              w_accept;
    logic              w_pop;
    logic [2*N_PE-1:0] w_shift;
    logic [N_PE-1:0]   w_rot;
    logic [IDX_W-1:0]  w_ofs;
    logic [IDX_W:0]    w_sum;
    logic [IDX_W-1:0]  w_winner;
    logic [N_PE-1:0]   w_gnt;
    logic [ADDR_L-1:0] w_sel_addr;
    logic [N_PE-1:0]   w_head_oh;

    assign w_slot_free = !r_mem_addr_req || mem_addr_gnt;
    assign w_accept    = rst && (|pe_addr_req) && w_slot_free && (r_cnt < CNT_MAX);
    assign w_pop       = mem_data_vld && (r_cnt != '0);

    // Rotate requests so the RR pointer sits at bit 0, then take the lowest set bit.
    assign w_shift = {pe_addr_req, pe_addr_req} >> r_rr_ptr;
    assign w_rot   = w_shift[N_PE-1:0];

    always_comb begin
        w_ofs = '0;
        for (int k = N_PE - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_ofs = IDX_W'(k);
            end
        end
        w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_ofs};
        w_winner = (w_sum >= N_PE_EXT) ? IDX_W'(w_sum - N_PE_EXT) : w_sum[IDX_W-1:0];
    end

    always_comb begin
        w_gnt           = '0;
        w_gnt[w_winner] = w_accept;
    end

    always_comb begin
        w_sel_addr = '0;
        for (int k = 0; k < N_PE; k++) begin
            if (w_winner == IDX_W'(k)) begin
                w_sel_addr = pe_addr[k*ADDR_L +: ADDR_L];
            end
        end
    end

    always_comb begin
        w_head_oh                   = '0;
        w_head_oh[r_tag[r_rd_ptr]]  = 1'b1;
    end

    // Tag storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag[r_wr_ptr] <= w_winner;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr       <= '0;
            r_mem_addr     <= '0;
            r_mem_addr_req <= 1'b0;
            r_wr_ptr       <= '0;
        end else if (w_accept) begin
            r_rr_ptr       <= (w_winner == LAST_PE) ? '0 : w_winner + 1'b1;
            r_mem_addr     <= w_sel_addr;
            r_mem_addr_req <= 1'b1;
            r_wr_ptr       <= r_wr_ptr + 1'b1;
        end else if (mem_addr_gnt) begin
            r_mem_addr_req <= 1'b0;
        end
    end

    // Return path: a word arriving with nothing outstanding is dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pe_data     <= '0;
            r_pe_data_vld <= '0;
            r_rd_ptr      <= '0;
            r_err         <= 1'b0;
        end else begin
            r_pe_data_vld <= '0;
            if (w_pop) begin
                r_pe_data     <= mem_data;
                r_pe_data_vld <= w_head_oh;
                r_rd_ptr      <= r_rd_ptr + 1'b1;
            end else if (mem_data_vld) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_accept && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!w_accept && w_pop) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign pe_addr_gnt     = w_gnt;
    assign pe_data         = r_pe_data;
    assign pe_data_vld     = r_pe_data_vld;
    assign mem_addr        = r_mem_addr;
    assign mem_addr_req    = r_mem_addr_req;
    assign outstanding_cnt = r_cnt;
    assign protocol_err    = r_err;

endmodule

// File: tb/tb_global_mem_ld_arbiter.sv
// Cycle-level bench for global_mem_ld_arbiter: a reference model predicts grants and
// slot state, and a scoreboard queue predicts which PE receives each returned word.
module tb_global_mem_ld_arbiter;

    localparam int N_PE    = 8;
    localparam int ADDR_L  = 24;
    localparam int DATA_L  = 32;
    localparam int MAX_OUT = 8;
    localparam int CNT_W   = 4;

    logic                      clk;
    logic                      rst;
    logic [N_PE*ADDR_L-1:0]    pe_addr;
    logic [N_PE-1:0]           pe_addr_req;
    logic [N_PE-1:0]           pe_addr_gnt;
    logic [DATA_L-1:0]         pe_data;
    logic [N_PE-1:0]           pe_data_vld;
    logic [ADDR_L-1:0]         mem_addr;
    logic                      mem_addr_req;
    logic                      mem_addr_gnt;
    logic [DATA_L-1:0]         mem_data;
    logic                      mem_data_vld;
    logic [CNT_W-1:0]          outstanding_cnt;
    logic                      protocol_err;

    typedef struct {
        int                pe;
        logic [DATA_L-1:0] data;
    } scoreEntry_t;

    typedef struct {
        int                ready;
        logic [DATA_L-1:0] data;
    } pendEntry_t;

    int vectorsApplied = 0;
    int miscompares    = 0;
    int cycleNo        = 0;

    logic [ADDR_L-1:0] peAddr [N_PE];
    logic [N_PE-1:0]   curReq;
    logic              curMemGnt;
    bit                memRespond;
    int                memLat;
    bit                strayReturn;
    logic [DATA_L-1:0] strayData;

    int                mRr;
    logic              mReq;
    logic [ADDR_L-1:0] mAddr;
    logic [DATA_L-1:0] mData;
    logic [N_PE-1:0]   expVld;
    logic              mErr;
    scoreEntry_t       sbQ [$];
    pendEntry_t        pendQ [$];

    global_mem_ld_arbiter #(
        .N_PE(N_PE), .ADDR_L(ADDR_L), .DATA_L(DATA_L), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pe_addr(pe_addr),
        .pe_addr_req(pe_addr_req),
        .pe_addr_gnt(pe_addr_gnt),
        .pe_data(pe_data),
        .pe_data_vld(pe_data_vld),
        .mem_addr(mem_addr),
        .mem_addr_req(mem_addr_req),
        .mem_addr_gnt(mem_addr_gnt),
        .mem_data(mem_data),
        .mem_data_vld(mem_data_vld),
        .outstanding_cnt(outstanding_cnt),
        .protocol_err(protocol_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycleNo);
        end
    endtask

    task automatic resetModel();
        mRr    = 0;
        mReq   = 1'b0;
        mAddr  = '0;
        mData  = '0;
        expVld = '0;
        mErr   = 1'b0;
        sbQ.delete();
    endtask

    // One clock cycle: drive inputs just after an edge, check the combinational grant,
    // advance the model across the edge, then check every registered output.
    task automatic applyStimulus();
        logic        droveVld;
        logic        expAcc;
        logic        found;
        logic [N_PE-1:0] expGnt;
        int          expWin;
        int          idx;
        int          sizeBefore;
        scoreEntry_t ent;
        pendEntry_t  pend;

        for (int i = 0; i < N_PE; i++) begin
            pe_addr[i*ADDR_L +: ADDR_L] = peAddr[i];
        end
        pe_addr_req  = curReq;
        mem_addr_gnt = curMemGnt;
        droveVld     = 1'b0;
        if (strayReturn) begin
            mem_data_vld = 1'b1;
            mem_data     = strayData;
            droveVld     = 1'b1;
            strayReturn  = 1'b0;
        end else if (memRespond && pendQ.size() != 0 && pendQ[0].ready <= cycleNo) begin
            mem_data_vld = 1'b1;
            mem_data     = pendQ[0].data;
            droveVld     = 1'b1;
            void'(pendQ.pop_front());
        end else begin
            mem_data_vld = 1'b0;
            mem_data     = $urandom;
        end
        #1;

        expAcc = rst && (curReq != '0) && (!mReq || curMemGnt) && (sbQ.size() < MAX_OUT);
        expWin = 0;
        found  = 1'b0;
        for (int k = 0; k < N_PE; k++) begin
            idx = (mRr + k) % N_PE;
            if (!found && curReq[idx]) begin
                found  = 1'b1;
                expWin = idx;
            end
        end
        expGnt = expAcc ? (N_PE'(1) << expWin) : '0;
        checkOutput("pe_addr_gnt", 64'(pe_addr_gnt), 64'(expGnt));

        if (rst && mem_addr_req && mem_addr_gnt) begin
            pend.ready = cycleNo + memLat;
            pend.data  = DATA_L'(mem_addr);
            pendQ.push_back(pend);
        end

        @(posedge clk);
        if (rst) begin
            sizeBefore = sbQ.size();
            if (droveVld && sizeBefore == 0) begin
                mErr = 1'b1;
            end
            if (droveVld && sizeBefore > 0) begin
                ent    = sbQ.pop_front();
                expVld = N_PE'(1) << ent.pe;
                mData  = ent.data;
            end else begin
                expVld = '0;
            end
            if (expAcc) begin
                ent.pe   = expWin;
                ent.data = DATA_L'(peAddr[expWin]);
                sbQ.push_back(ent);
                mReq  = 1'b1;
                mAddr = peAddr[expWin];
                mRr   = (expWin + 1) % N_PE;
            end else if (curMemGnt) begin
                mReq = 1'b0;
            end
        end
        cycleNo++;
        #1;

        checkOutput("pe_data_vld", 64'(pe_data_vld), 64'(expVld));
        checkOutput("pe_data", 64'(pe_data), 64'(mData));
        checkOutput("mem_addr_req", 64'(mem_addr_req), 64'(mReq));
        checkOutput("mem_addr", 64'(mem_addr), 64'(mAddr));
        checkOutput("outstanding_cnt", 64'(outstanding_cnt), 64'(sbQ.size()));
        checkOutput("protocol_err", 64'(protocol_err), 64'(mErr));
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus();
        end
    endtask

    task automatic pulseReset(input int n);
        rst = 1'b0;
        resetModel();
        runCycles(n);
        pendQ.delete();
        rst = 1'b1;
    endtask

    // Directed scenarios run back to back; the model checks every cycle of each.
    initial begin
        rst          = 1'b1;
        pe_addr      = '0;
        pe_addr_req  = '0;
        mem_addr_gnt = 1'b0;
        mem_data     = '0;
        mem_data_vld = 1'b0;
        curReq       = '0;
        curMemGnt    = 1'b0;
        memRespond   = 1'b0;
        memLat       = 2;
        strayReturn  = 1'b0;
        strayData    = '0;
        for (int i = 0; i < N_PE; i++) begin
            peAddr[i] = ADDR_L'(24'h100 * (i + 1));
        end
        resetModel();
        #2;
        @(posedge clk);
        #1;
        curReq = 8'hFF;
        pulseReset(3);
        curReq = '0;

        $display("[TB] single PE3 issuing three loads");
        curMemGnt  = 1'b1;
        memRespond = 1'b1;
        memLat     = 2;
        curReq     = 8'h08;
        peAddr[3]  = 24'h00000A;
        applyStimulus();
        peAddr[3]  = 24'h00000B;
        applyStimulus();
        peAddr[3]  = 24'h00000C;
        applyStimulus();
        curReq = '0;
        runCycles(8);

        $display("[TB] all PEs requesting from pointer 0");
        pulseReset(2);
        for (int i = 0; i < N_PE; i++) begin
            peAddr[i] = ADDR_L'(24'h1000 + i);
        end
        memLat = 1;
        curReq = 8'hFF;
        runCycles(9);
        curReq = '0;
        runCycles(8);

        $display("[TB] memory address stall");
        curReq    = 8'h01;
        curMemGnt = 1'b1;
        applyStimulus();
        curMemGnt = 1'b0;
        curReq    = 8'hFF;
        runCycles(5);
        curMemGnt = 1'b1;
        runCycles(3);
        curReq = '0;
        runCycles(8);

        $display("[TB] outstanding limit with no returns");
        memRespond = 1'b0;
        curReq     = 8'hFF;
        runCycles(12);
        memRespond = 1'b1;
        applyStimulus();
        memRespond = 1'b0;
        runCycles(4);
        curReq     = '0;
        memRespond = 1'b1;
        runCycles(20);

        $display("[TB] interleaved PE2/PE5/PE2 loads");
        pulseReset(2);
        memLat    = 1;
        curReq    = 8'h04;
        peAddr[2] = 24'h000011;
        applyStimulus();
        curReq    = 8'h20;
        peAddr[5] = 24'h000022;
        applyStimulus();
        curReq    = 8'h04;
        peAddr[2] = 24'h000033;
        applyStimulus();
        curReq = '0;
        runCycles(6);

        $display("[TB] stray return and mid-stream reset");
        strayReturn = 1'b1;
        strayData   = 32'hDEAD_BEEF;
        applyStimulus();
        runCycles(2);
        memLat = 2;
        curReq = 8'hFF;
        runCycles(4);
        pulseReset(3);
        curReq = '0;
        runCycles(2);
        strayReturn = 1'b1;
        strayData   = 32'h1234_5678;
        applyStimulus();
        runCycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
